// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the in-order pipeline: sequences jumps, MDU
// waits, bus wait states and interrupt entry. It drives the stall and flush
// controls of the PC, IF/ID and ID/EX registers, and counts stalled cycles.
module pipe_hazard_ctrl #(
  parameter int unsigned              ADDR_W  = 32,
  parameter int unsigned              CNT_W   = 16,
  parameter logic [ADDR_W-1:0]        IRQ_VEC = ADDR_W'(32'h0000_0004)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              jump_req_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              load_use_i,
  input  logic              mdu_req_i,
  input  logic              mdu_done_i,
  input  logic              bus_req_i,
  input  logic              bus_gnt_i,
  input  logic              irq_req_i,
  output logic              stall_pc_o,
  output logic              stall_if_o,
  output logic              stall_ex_o,
  output logic              flush_if_o,
  output logic              flush_ex_o,
  output logic              jump_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic              irq_ack_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_MDU_WAIT  = 3'd1,
    ST_BUS_WAIT  = 3'd2,
    ST_IRQ_FLUSH = 3'd3,
    ST_IRQ_JUMP  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic               stall_pc_s, stall_if_s, stall_ex_s;
  logic               flush_if_s, flush_ex_s;
  logic               jump_s, irq_ack_s;
  logic [ADDR_W-1:0]  jump_addr_s;

  // Next-state and raw control outputs; reset drives bubbles into both stages.
  always_comb begin
    state_d     = state_q;
    stall_pc_s  = 1'b0;
    stall_if_s  = 1'b0;
    stall_ex_s  = 1'b0;
    flush_if_s  = 1'b0;
    flush_ex_s  = 1'b0;
    jump_s      = 1'b0;
    irq_ack_s   = 1'b0;
    jump_addr_s = {ADDR_W{1'b0}};
    if (!rstn) begin
      flush_if_s = 1'b1;
      flush_ex_s = 1'b1;
      state_d    = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (jump_req_i) begin
            jump_s      = 1'b1;
            jump_addr_s = jump_addr_i;
            flush_if_s  = 1'b1;
            flush_ex_s  = 1'b1;
          end else if (mdu_req_i && !mdu_done_i) begin
            stall_pc_s = 1'b1;
            stall_if_s = 1'b1;
            stall_ex_s = 1'b1;
            state_d    = ST_MDU_WAIT;
          end else if (bus_req_i && !bus_gnt_i) begin
            stall_pc_s = 1'b1;
            stall_if_s = 1'b1;
            stall_ex_s = 1'b1;
            state_d    = ST_BUS_WAIT;
          end else if (irq_req_i) begin
            stall_pc_s = 1'b1;
            flush_if_s = 1'b1;
            flush_ex_s = 1'b1;
            state_d    = ST_IRQ_FLUSH;
          end else if (load_use_i) begin
            stall_pc_s = 1'b1;
            stall_if_s = 1'b1;
            flush_ex_s = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_MDU_WAIT: begin
          if (mdu_done_i) begin
            state_d = ST_RUN;
          end else begin
            stall_pc_s = 1'b1;
            stall_if_s = 1'b1;
            stall_ex_s = 1'b1;
          end
        end
        ST_BUS_WAIT: begin
          if (bus_gnt_i) begin
            state_d = ST_RUN;
          end else begin
            stall_pc_s = 1'b1;
            stall_if_s = 1'b1;
            stall_ex_s = 1'b1;
          end
        end
        ST_IRQ_FLUSH: begin
          stall_pc_s = 1'b1;
          flush_if_s = 1'b1;
          flush_ex_s = 1'b1;
          state_d    = ST_IRQ_JUMP;
        end
        ST_IRQ_JUMP: begin
          jump_s      = 1'b1;
          jump_addr_s = IRQ_VEC;
          flush_if_s  = 1'b1;
          flush_ex_s  = 1'b1;
          irq_ack_s   = 1'b1;
          state_d     = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // A flushed register never also holds: flush overrides stall per stage.
  always_comb begin
    stall_pc_o  = stall_pc_s;
    stall_if_o  = stall_if_s & ~flush_if_s;
    stall_ex_o  = stall_ex_s & ~flush_ex_s;
    flush_if_o  = flush_if_s;
    flush_ex_o  = flush_ex_s;
    jump_o      = jump_s;
    jump_addr_o = jump_addr_s;
    irq_ack_o   = irq_ack_s;
    stall_cnt_o = stall_cnt_q;
  end

  // Saturating count of cycles in which the PC was held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!rstn) begin
      stall_cnt_d = {CNT_W{1'b0}};
    end else if (stall_pc_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State and counter registers; reset is folded into the _d logic.
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    stall_cnt_q <= stall_cnt_d;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: per-feature tasks with inline checks.
// Inputs change on the falling edge and outputs are sampled 2 ns later.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        jump_req_i, load_use_i, mdu_req_i, mdu_done_i;
  logic        bus_req_i, bus_gnt_i, irq_req_i;
  logic [31:0] jump_addr_i;

  logic        stall_pc_o, stall_if_o, stall_ex_o, flush_if_o, flush_ex_o;
  logic        jump_o, irq_ack_o;
  logic [31:0] jump_addr_o;
  logic [15:0] stall_cnt_o;

  logic        n_stall_pc_o, n_stall_if_o, n_stall_ex_o, n_flush_if_o, n_flush_ex_o;
  logic        n_jump_o, n_irq_ack_o;
  logic [31:0] n_jump_addr_o;
  logic [3:0]  n_stall_cnt_o;

  logic [6:0]  flags;
  int          checks = 0;
  int          failures = 0;
  int          exp_cnt = 0;

  // flag order: stall_pc, stall_if, stall_ex, flush_if, flush_ex, jump, irq_ack
  localparam logic [6:0] F_IDLE  = 7'b000_00_0_0;
  localparam logic [6:0] F_RST   = 7'b000_11_0_0;
  localparam logic [6:0] F_JUMP  = 7'b000_11_1_0;
  localparam logic [6:0] F_STALL = 7'b111_00_0_0;
  localparam logic [6:0] F_IRQF  = 7'b100_11_0_0;
  localparam logic [6:0] F_IRQJ  = 7'b000_11_1_1;
  localparam logic [6:0] F_LU    = 7'b110_01_0_0;

  assign flags = {stall_pc_o, stall_if_o, stall_ex_o, flush_if_o, flush_ex_o, jump_o, irq_ack_o};

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rstn(rstn),
    .jump_req_i(jump_req_i), .jump_addr_i(jump_addr_i), .load_use_i(load_use_i),
    .mdu_req_i(mdu_req_i), .mdu_done_i(mdu_done_i),
    .bus_req_i(bus_req_i), .bus_gnt_i(bus_gnt_i), .irq_req_i(irq_req_i),
    .stall_pc_o(stall_pc_o), .stall_if_o(stall_if_o), .stall_ex_o(stall_ex_o),
    .flush_if_o(flush_if_o), .flush_ex_o(flush_ex_o),
    .jump_o(jump_o), .jump_addr_o(jump_addr_o), .irq_ack_o(irq_ack_o),
    .stall_cnt_o(stall_cnt_o)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) dut_n (
    .clk(clk), .rstn(rstn),
    .jump_req_i(jump_req_i), .jump_addr_i(jump_addr_i), .load_use_i(load_use_i),
    .mdu_req_i(mdu_req_i), .mdu_done_i(mdu_done_i),
    .bus_req_i(bus_req_i), .bus_gnt_i(bus_gnt_i), .irq_req_i(irq_req_i),
    .stall_pc_o(n_stall_pc_o), .stall_if_o(n_stall_if_o), .stall_ex_o(n_stall_ex_o),
    .flush_if_o(n_flush_if_o), .flush_ex_o(n_flush_ex_o),
    .jump_o(n_jump_o), .jump_addr_o(n_jump_addr_o), .irq_ack_o(n_irq_ack_o),
    .stall_cnt_o(n_stall_cnt_o)
  );

  // Apply one cycle of inputs at the falling edge, then settle before sampling.
  task automatic step(input logic r, input logic jr, input logic [31:0] ja, input logic lu,
                      input logic mr, input logic md, input logic br, input logic bg,
                      input logic ir);
    @(negedge clk);
    rstn = r; jump_req_i = jr; jump_addr_i = ja; load_use_i = lu;
    mdu_req_i = mr; mdu_done_i = md; bus_req_i = br; bus_gnt_i = bg; irq_req_i = ir;
    #2;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (flags !== F_RST || jump_addr_o !== 32'h0) begin
        $display("FAIL reset_hold flags=%b addr=%h expected flags=%b addr=0", flags, jump_addr_o, F_RST);
        failures++;
      end
    end
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (flags !== F_IDLE || stall_cnt_o !== 16'd0 || n_stall_cnt_o !== 4'd0) begin
      $display("FAIL reset_release flags=%b cnt=%0d ncnt=%0d expected flags=%b cnt=0", flags, stall_cnt_o, n_stall_cnt_o, F_IDLE);
      failures++;
    end
    exp_cnt = 0;
  endtask

  task automatic test_jump();
    step(1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (flags !== F_JUMP || jump_addr_o !== 32'h80) begin
      $display("FAIL jump flags=%b addr=%h expected flags=%b addr=80", flags, jump_addr_o, F_JUMP);
      failures++;
    end
    step(1'b1, 1'b0, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (flags !== F_IDLE || jump_addr_o !== 32'h0 || stall_cnt_o !== 16'(exp_cnt)) begin
      $display("FAIL jump_after flags=%b addr=%h cnt=%0d expected flags=%b addr=0 cnt=%0d", flags, jump_addr_o, stall_cnt_o, F_IDLE, exp_cnt);
      failures++;
    end
  endtask

  task automatic test_mdu();
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (flags !== F_STALL) begin
      $display("FAIL mdu_issue flags=%b expected %b", flags, F_STALL);
      failures++;
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (flags !== F_STALL) begin
        $display("FAIL mdu_wait%0d flags=%b expected %b", i, flags, F_STALL);
        failures++;
      end
    end
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_cnt += 4;
    checks++;
    if (flags !== F_IDLE || stall_cnt_o !== 16'(exp_cnt)) begin
      $display("FAIL mdu_done flags=%b cnt=%0d expected flags=%b cnt=%0d", flags, stall_cnt_o, F_IDLE, exp_cnt);
      failures++;
    end
    // done in the issue cycle: no stall at all
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (flags !== F_IDLE) begin
      $display("FAIL mdu_same_cycle_done flags=%b expected %b", flags, F_IDLE);
      failures++;
    end
    // jump, load-use and irq are ignored while waiting on the MDU
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (flags !== F_STALL || jump_addr_o !== 32'h0) begin
      $display("FAIL mdu_ignore flags=%b addr=%h expected flags=%b addr=0", flags, jump_addr_o, F_STALL);
      failures++;
    end
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_cnt += 2;
    checks++;
    if (flags !== F_IDLE || stall_cnt_o !== 16'(exp_cnt)) begin
      $display("FAIL mdu_ignore_done flags=%b cnt=%0d expected flags=%b cnt=%0d", flags, stall_cnt_o, F_IDLE, exp_cnt);
      failures++;
    end
  endtask

  task automatic test_irq_jump();
    step(1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (flags !== F_JUMP || jump_addr_o !== 32'h80) begin
      $display("FAIL irq_jump_first flags=%b addr=%h expected flags=%b addr=80", flags, jump_addr_o, F_JUMP);
      failures++;
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (flags !== F_IRQF || jump_addr_o !== 32'h0) begin
        $display("FAIL irq_flush%0d flags=%b addr=%h expected flags=%b addr=0", i, flags, jump_addr_o, F_IRQF);
        failures++;
      end
    end
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (flags !== F_IRQJ || jump_addr_o !== 32'h4) begin
      $display("FAIL irq_vector flags=%b addr=%h expected flags=%b addr=4", flags, jump_addr_o, F_IRQJ);
      failures++;
    end
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_cnt += 2;
    checks++;
    if (flags !== F_IDLE || stall_cnt_o !== 16'(exp_cnt)) begin
      $display("FAIL irq_after flags=%b cnt=%0d expected flags=%b cnt=%0d", flags, stall_cnt_o, F_IDLE, exp_cnt);
      failures++;
    end
  endtask

  task automatic test_load_use();
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (flags !== F_LU) begin
      $display("FAIL load_use flags=%b expected %b", flags, F_LU);
      failures++;
    end
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_cnt += 1;
    checks++;
    if (flags !== F_IDLE || stall_cnt_o !== 16'(exp_cnt)) begin
      $display("FAIL load_use_after flags=%b cnt=%0d expected flags=%b cnt=%0d", flags, stall_cnt_o, F_IDLE, exp_cnt);
      failures++;
    end
    // MDU outranks load-use
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (flags !== F_STALL) begin
      $display("FAIL mdu_over_load_use flags=%b expected %b", flags, F_STALL);
      failures++;
    end
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_cnt += 1;
  endtask

  task automatic test_bus();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (flags !== F_STALL) begin
        $display("FAIL bus_wait%0d flags=%b expected %b", i, flags, F_STALL);
        failures++;
      end
    end
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_cnt += 2;
    checks++;
    if (flags !== F_IDLE || stall_cnt_o !== 16'(exp_cnt)) begin
      $display("FAIL bus_grant flags=%b cnt=%0d expected flags=%b cnt=%0d", flags, stall_cnt_o, F_IDLE, exp_cnt);
      failures++;
    end
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (flags !== F_IDLE) begin
      $display("FAIL bus_same_cycle_grant flags=%b expected %b", flags, F_IDLE);
      failures++;
    end
  endtask

  task automatic test_saturate_and_reset();
    int bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (flags !== F_STALL) bad++;
    end
    checks++;
    if (bad != 0) begin
      $display("FAIL bus_long_wait bad_cycles=%0d expected 0", bad);
      failures++;
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_cnt += 20;
    checks++;
    if (n_stall_cnt_o !== 4'hF || stall_cnt_o !== 16'(exp_cnt)) begin
      $display("FAIL cnt_saturate ncnt=%h cnt=%0d expected ncnt=f cnt=%0d", n_stall_cnt_o, stall_cnt_o, exp_cnt);
      failures++;
    end
    checks++;
    if (flags !== F_RST) begin
      $display("FAIL reset_in_bus_wait flags=%b expected %b", flags, F_RST);
      failures++;
    end
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (flags !== F_IDLE || stall_cnt_o !== 16'd0 || n_stall_cnt_o !== 4'd0) begin
      $display("FAIL reset_abandon flags=%b cnt=%0d ncnt=%0d expected flags=%b cnt=0", flags, stall_cnt_o, n_stall_cnt_o, F_IDLE);
      failures++;
    end
  endtask

  initial begin
    rstn = 1'b0; jump_req_i = 1'b0; jump_addr_i = 32'h0; load_use_i = 1'b0;
    mdu_req_i = 1'b0; mdu_done_i = 1'b0; bus_req_i = 1'b0; bus_gnt_i = 1'b0; irq_req_i = 1'b0;
    test_reset();
    test_jump();
    test_mdu();
    test_irq_jump();
    test_load_use();
    test_bus();
    test_saturate_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
